// File: rtl/hsv_pkg.sv
// Shared constants, mode encodings, FSM state type and triple struct
// for the HSV mode sequencer.
package hsv_pkg;

    localparam int HUE_MAX   = 359;
    localparam int HUE_MOD   = 360;
    localparam int HUE_STEP  = 60;
    localparam int PCT_MAX   = 100;
    localparam int HUE_FIXED = 120;
    localparam int PASTEL    = 50;

    // Update rules selected by sost; codes 7..15 leave the triple unchanged.
    localparam logic [3:0] MODE_HUE_FIX = 4'd0;
    localparam logic [3:0] MODE_ROTATE  = 4'd1;
    localparam logic [3:0] MODE_HUE_INC = 4'd2;
    localparam logic [3:0] MODE_EXT_HUE = 4'd3;
    localparam logic [3:0] MODE_EXT_VAL = 4'd4;
    localparam logic [3:0] MODE_EXT_SAT = 4'd5;
    localparam logic [3:0] MODE_PASTEL  = 4'd6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        APPLY = 2'd2,
        SEND  = 2'd3
    } state_t;

    typedef struct packed {
        logic [8:0] hue;
        logic [6:0] sat;
        logic [6:0] val;
    } hsv_t;

    // Saturating clamp of a 7-bit percentage input to 0..100.
    function automatic logic [6:0] clamp_pct(input logic [6:0] x);
        return (x > 7'(PCT_MAX)) ? 7'(PCT_MAX) : x;
    endfunction

endpackage

// File: rtl/hsv_step_calc.sv
// Combinational next-triple calculation: applies the rule selected by the
// latched mode to the current triple, including hue wrap and input clamps.
module hsv_step_calc
    import hsv_pkg::*;
(
    input  logic [3:0] mode_q,
    input  logic [8:0] hue,
    input  logic [6:0] sat,
    input  logic [6:0] val,
    input  logic [8:0] h_in,
    input  logic [6:0] s_in,
    input  logic [6:0] v_in,
    output hsv_t       nxt
);

    // 10-bit sums so the wrap compare sees the carry past 511 never needed,
    // but values 360..419 are representable before subtraction.
    logic [9:0] hue_rot;
    logic [9:0] hue_inc;

    // Select the new triple; unlisted fields hold their current value.
    always_comb begin
        hue_rot = {1'b0, hue} + 10'(HUE_STEP);
        hue_inc = {1'b0, hue} + 10'd1;
        nxt.hue = hue;
        nxt.sat = sat;
        nxt.val = val;
        case (mode_q)
            MODE_HUE_FIX: nxt.hue = 9'(HUE_FIXED);
            MODE_ROTATE:  nxt.hue = (hue_rot >= 10'(HUE_MOD)) ? 9'(hue_rot - 10'(HUE_MOD))
                                                              : hue_rot[8:0];
            MODE_HUE_INC: nxt.hue = (hue_inc >= 10'(HUE_MOD)) ? 9'd0 : hue_inc[8:0];
            MODE_EXT_HUE: nxt.hue = (h_in > 9'(HUE_MAX)) ? 9'(HUE_MAX) : h_in;
            MODE_EXT_VAL: nxt.val = clamp_pct(v_in);
            MODE_EXT_SAT: nxt.sat = clamp_pct(s_in);
            MODE_PASTEL: begin
                nxt.sat = 7'(PASTEL);
                nxt.val = 7'(PASTEL);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hsv_mode_sequencer.sv
// Mode sequencer: holds the HSV triple, updates it on a fixed step period or
// immediately on a mode change, and offers each new triple downstream through
// a valid/ready handshake. The step counter only runs while waiting in COUNT,
// so a stalled converter stretches the period instead of dropping updates.
module hsv_mode_sequencer
    import hsv_pkg::*;
#(
    parameter int STEP_CYCLES = 10000000,
    parameter int HUE_INIT    = 120,
    parameter int PCT_INIT    = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sost,
    input  logic [8:0] h_in,
    input  logic [6:0] s_in,
    input  logic [6:0] v_in,
    output logic [8:0] hue,
    output logic [6:0] sat,
    output logic [6:0] val,
    output logic       hsv_valid,
    input  logic       hsv_ready,
    output logic       mode_ack
);

    localparam int              CNT_W    = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
    logic [3:0]       mode_q, mode_q_nxt;
    logic             mode_chg, mode_chg_nxt;
    logic             hsv_valid_nxt;
    logic             mode_ack_nxt;
    hsv_t             calc;

    hsv_step_calc u_calc (
        .mode_q (mode_q),
        .hue    (hue),
        .sat    (sat),
        .val    (val),
        .h_in   (h_in),
        .s_in   (s_in),
        .v_in   (v_in),
        .nxt    (calc)
    );

    // Next-state logic; a mode change takes priority over the period expiry.
    always_comb begin
        state_nxt    = state;
        step_cnt_nxt = step_cnt;
        mode_q_nxt   = mode_q;
        mode_chg_nxt = mode_chg;
        case (state)
            IDLE: state_nxt = APPLY;
            COUNT: begin
                if (sost != mode_q) begin
                    mode_q_nxt   = sost;
                    mode_chg_nxt = 1'b1;
                    step_cnt_nxt = '0;
                    state_nxt    = APPLY;
                end else if (step_cnt == CNT_LAST) begin
                    step_cnt_nxt = '0;
                    state_nxt    = APPLY;
                end else begin
                    step_cnt_nxt = step_cnt + CNT_W'(1);
                end
            end
            APPLY: begin
                mode_chg_nxt = 1'b0;
                state_nxt    = SEND;
            end
            SEND: begin
                if (hsv_valid && hsv_ready) begin
                    step_cnt_nxt = '0;
                    state_nxt    = COUNT;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        hsv_valid_nxt = (state_nxt == SEND);
        mode_ack_nxt  = (state_nxt == APPLY) && mode_chg_nxt;
    end

    // State, counter, mode latch and handshake/ack registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            step_cnt  <= '0;
            mode_q    <= MODE_HUE_FIX;
            mode_chg  <= 1'b0;
            hsv_valid <= 1'b0;
            mode_ack  <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_cnt  <= step_cnt_nxt;
            mode_q    <= mode_q_nxt;
            mode_chg  <= mode_chg_nxt;
            hsv_valid <= hsv_valid_nxt;
            mode_ack  <= mode_ack_nxt;
        end
    end

    // Triple registers change only in APPLY, so they are stable through SEND.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hue <= 9'(HUE_INIT);
            sat <= 7'(PCT_INIT);
            val <= 7'(PCT_INIT);
        end else if (state == APPLY) begin
            hue <= calc.hue;
            sat <= calc.sat;
            val <= calc.val;
        end
    end

endmodule

// File: tb/tb_hsv_mode_sequencer.sv
// Self-checking bench for hsv_mode_sequencer with STEP_CYCLES = 8.
// Frames are compared against a rule-level model of the triple and against
// the expected spacing between successive hsv_valid rises.
module tb_hsv_mode_sequencer;

    localparam int STEP = 8;
    localparam int PER  = STEP + 2;  // periodic frame spacing with ready held high
    localparam int CHG  = 3;         // frame spacing when sost changes during SEND

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] sost = 4'd0;
    logic [8:0] h_in = 9'd0;
    logic [6:0] s_in = 7'd0;
    logic [6:0] v_in = 7'd0;
    logic [8:0] hue;
    logic [6:0] sat;
    logic [6:0] val;
    logic       hsv_valid;
    logic       hsv_ready = 1'b1;
    logic       mode_ack;

    int n_checks = 0;
    int n_pass   = 0;
    int m_h, m_s, m_v;     // reference triple
    int cur_mode = 0;      // mode the DUT should currently hold

    hsv_mode_sequencer #(.STEP_CYCLES(STEP), .HUE_INIT(120), .PCT_INIT(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .sost      (sost),
        .h_in      (h_in),
        .s_in      (s_in),
        .v_in      (v_in),
        .hue       (hue),
        .sat       (sat),
        .val       (val),
        .hsv_valid (hsv_valid),
        .hsv_ready (hsv_ready),
        .mode_ack  (mode_ack)
    );

    always #5 clk = ~clk;

    // Reference rules applied to the model triple, using current external inputs.
    task automatic model_apply(input int mode);
        case (mode)
            0: m_h = 120;
            1: m_h = (m_h + 60) % 360;
            2: m_h = (m_h + 1) % 360;
            3: m_h = (int'(h_in) > 359) ? 359 : int'(h_in);
            4: m_v = (int'(v_in) > 100) ? 100 : int'(v_in);
            5: m_s = (int'(s_in) > 100) ? 100 : int'(s_in);
            6: begin m_s = 50; m_v = 50; end
            default: ;
        endcase
    endtask

    // Wait (bounded) for hsv_valid; dt = negedges waited, acks = mode_ack pulses seen.
    task automatic get_frame(input int max_wait, output int dt, output int acks);
        dt = 0;
        acks = 0;
        do begin
            @(negedge clk);
            dt++;
            if (mode_ack) acks++;
        end while (!hsv_valid && dt <= max_wait);
    endtask

    task automatic test_reset();
        int dt, acks;
        reset = 1'b1; sost = 4'd0; hsv_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (hsv_valid !== 1'b0 || mode_ack !== 1'b0 || hue !== 9'd120 || sat !== 7'd100 || val !== 7'd100)
            $display("FAIL reset_state: got v=%0b a=%0b hsv=%0d/%0d/%0d, want v=0 a=0 hsv=120/100/100",
                     hsv_valid, mode_ack, hue, sat, val);
        else n_pass++;
        reset = 1'b0;
        m_h = 120; m_s = 100; m_v = 100; cur_mode = 0;
        for (int f = 0; f < 3; f++) begin
            get_frame(40, dt, acks);
            model_apply(0);
            n_checks++;
            if (dt !== ((f == 0) ? 2 : PER) || acks !== 0 || hue !== 9'(m_h) || sat !== 7'(m_s) || val !== 7'(m_v))
                $display("FAIL reset_frames f=%0d: got dt=%0d ack=%0d hsv=%0d/%0d/%0d, want dt=%0d ack=0 hsv=%0d/%0d/%0d",
                         f, dt, acks, hue, sat, val, (f == 0) ? 2 : PER, m_h, m_s, m_v);
            else n_pass++;
        end
    endtask

    task automatic test_rotate();
        int dt, acks;
        sost = 4'd1; cur_mode = 1;
        for (int f = 0; f < 5; f++) begin
            get_frame(40, dt, acks);
            model_apply(1);
            n_checks++;
            if (dt !== ((f == 0) ? CHG : PER) || acks !== ((f == 0) ? 1 : 0) ||
                hue !== 9'(m_h) || sat !== 7'(m_s) || val !== 7'(m_v))
                $display("FAIL rotate f=%0d: got dt=%0d ack=%0d hsv=%0d/%0d/%0d, want dt=%0d ack=%0d hsv=%0d/%0d/%0d",
                         f, dt, acks, hue, sat, val, (f == 0) ? CHG : PER, (f == 0) ? 1 : 0, m_h, m_s, m_v);
            else n_pass++;
        end
    endtask

    task automatic test_increment();
        int dt, acks, mode, edt, eack;
        for (int f = 0; f < 4; f++) begin
            if (f == 0) begin sost = 4'd3; h_in = 9'd358; end
            if (f == 1) sost = 4'd2;
            mode = int'(sost);
            edt  = (mode != cur_mode) ? CHG : PER;
            eack = (mode != cur_mode) ? 1 : 0;
            cur_mode = mode;
            get_frame(40, dt, acks);
            model_apply(mode);
            n_checks++;
            if (dt !== edt || acks !== eack || hue !== 9'(m_h) || sat !== 7'(m_s) || val !== 7'(m_v))
                $display("FAIL increment f=%0d: got dt=%0d ack=%0d hsv=%0d/%0d/%0d, want dt=%0d ack=%0d hsv=%0d/%0d/%0d",
                         f, dt, acks, hue, sat, val, edt, eack, m_h, m_s, m_v);
            else n_pass++;
        end
    endtask

    task automatic test_external();
        int dt, acks;
        int tbl_mode [4] = '{6, 3, 5, 4};
        int tbl_h    [4] = '{0, 400, 0, 0};
        int tbl_s    [4] = '{0, 0, 127, 0};
        int tbl_v    [4] = '{0, 0, 0, 64};
        for (int f = 0; f < 4; f++) begin
            sost = 4'(tbl_mode[f]); h_in = 9'(tbl_h[f]); s_in = 7'(tbl_s[f]); v_in = 7'(tbl_v[f]);
            cur_mode = tbl_mode[f];
            get_frame(40, dt, acks);
            model_apply(tbl_mode[f]);
            n_checks++;
            if (dt !== CHG || acks !== 1 || hue !== 9'(m_h) || sat !== 7'(m_s) || val !== 7'(m_v))
                $display("FAIL external f=%0d: got dt=%0d ack=%0d hsv=%0d/%0d/%0d, want dt=%0d ack=1 hsv=%0d/%0d/%0d",
                         f, dt, acks, hue, sat, val, CHG, m_h, m_s, m_v);
            else n_pass++;
        end
        n_checks++;
        if (hue !== 9'd359 || sat !== 7'd100 || val !== 7'd64)
            $display("FAIL external_final: got hsv=%0d/%0d/%0d, want hsv=359/100/64", hue, sat, val);
        else n_pass++;
    endtask

    task automatic test_stall();
        int dt, acks;
        sost = 4'd0; cur_mode = 0;
        get_frame(40, dt, acks);
        model_apply(0);
        n_checks++;
        if (dt !== CHG || acks !== 1 || hue !== 9'(m_h) || sat !== 7'(m_s) || val !== 7'(m_v))
            $display("FAIL stall_setup: got dt=%0d ack=%0d hsv=%0d/%0d/%0d, want dt=%0d ack=1 hsv=%0d/%0d/%0d",
                     dt, acks, hue, sat, val, CHG, m_h, m_s, m_v);
        else n_pass++;
        hsv_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 10) sost = 4'd6;
            n_checks++;
            if (hsv_valid !== 1'b1 || mode_ack !== 1'b0 || hue !== 9'(m_h) || sat !== 7'(m_s) || val !== 7'(m_v))
                $display("FAIL stall_hold i=%0d: got v=%0b a=%0b hsv=%0d/%0d/%0d, want v=1 a=0 hsv=%0d/%0d/%0d",
                         i, hsv_valid, mode_ack, hue, sat, val, m_h, m_s, m_v);
            else n_pass++;
        end
        hsv_ready = 1'b1; cur_mode = 6;
        for (int f = 0; f < 2; f++) begin
            get_frame(40, dt, acks);
            model_apply(6);
            n_checks++;
            if (dt !== ((f == 0) ? CHG : PER) || acks !== ((f == 0) ? 1 : 0) ||
                hue !== 9'(m_h) || sat !== 7'(m_s) || val !== 7'(m_v))
                $display("FAIL stall_release f=%0d: got dt=%0d ack=%0d hsv=%0d/%0d/%0d, want dt=%0d ack=%0d hsv=%0d/%0d/%0d",
                         f, dt, acks, hue, sat, val, (f == 0) ? CHG : PER, (f == 0) ? 1 : 0, m_h, m_s, m_v);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int dt, acks, mode, edt, eack, stall;
        for (int f = 0; f < 40; f++) begin
            stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0;
            if (stall > 0) begin
                hsv_ready = 1'b0;
                for (int i = 0; i < stall; i++) begin
                    @(negedge clk);
                    n_checks++;
                    if (hsv_valid !== 1'b1 || hue !== 9'(m_h) || sat !== 7'(m_s) || val !== 7'(m_v))
                        $display("FAIL random_stall f=%0d: got v=%0b hsv=%0d/%0d/%0d, want v=1 hsv=%0d/%0d/%0d",
                                 f, hsv_valid, hue, sat, val, m_h, m_s, m_v);
                    else n_pass++;
                end
                hsv_ready = 1'b1;
            end
            mode = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : cur_mode;
            if ($urandom_range(0, 1) == 1) begin
                h_in = 9'($urandom_range(0, 511));
                s_in = 7'($urandom_range(0, 127));
                v_in = 7'($urandom_range(0, 127));
            end
            sost = 4'(mode);
            edt  = (mode != cur_mode) ? CHG : PER;
            eack = (mode != cur_mode) ? 1 : 0;
            cur_mode = mode;
            get_frame(40, dt, acks);
            model_apply(mode);
            n_checks++;
            if (dt !== edt || acks !== eack || hue !== 9'(m_h) || sat !== 7'(m_s) || val !== 7'(m_v))
                $display("FAIL random f=%0d mode=%0d: got dt=%0d ack=%0d hsv=%0d/%0d/%0d, want dt=%0d ack=%0d hsv=%0d/%0d/%0d",
                         f, mode, dt, acks, hue, sat, val, edt, eack, m_h, m_s, m_v);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_send();
        int dt, acks;
        hsv_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (hsv_valid !== 1'b0 || mode_ack !== 1'b0 || hue !== 9'd120 || sat !== 7'd100 || val !== 7'd100)
            $display("FAIL reset_mid_send: got v=%0b a=%0b hsv=%0d/%0d/%0d, want v=0 a=0 hsv=120/100/100",
                     hsv_valid, mode_ack, hue, sat, val);
        else n_pass++;
        @(negedge clk);
        sost = 4'd0; hsv_ready = 1'b1; reset = 1'b0;
        m_h = 120; m_s = 100; m_v = 100; cur_mode = 0;
        for (int f = 0; f < 2; f++) begin
            get_frame(40, dt, acks);
            model_apply(0);
            n_checks++;
            if (dt !== ((f == 0) ? 2 : PER) || acks !== 0 || hue !== 9'(m_h) || sat !== 7'(m_s) || val !== 7'(m_v))
                $display("FAIL restart f=%0d: got dt=%0d ack=%0d hsv=%0d/%0d/%0d, want dt=%0d ack=0 hsv=%0d/%0d/%0d",
                         f, dt, acks, hue, sat, val, (f == 0) ? 2 : PER, m_h, m_s, m_v);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_increment();
        test_external();
        test_stall();
        test_random();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
